// File: rtl/ysyx_23060240_trap_seq.sv
// Trap sequencer: turns a retiring ECALL/MRET into an ordered CSR access sequence
// and a PC redirect, forwarding ordinary CSR instruction requests while idle.
module ysyx_23060240_trap_seq #(
    parameter logic [31:0] MCAUSE_ECALL = 32'hb,
    parameter int          CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inst_valid,
    input  logic [31:0]      pc,
    input  logic             jump_ecall,
    input  logic             jump_mret,
    input  logic [11:0]      inst_csr_addr,
    input  logic [31:0]      inst_csr_wdata,
    input  logic             inst_csr_wen,
    input  logic             inst_csr_ren,
    input  logic [31:0]      csr_rdata,
    output logic [11:0]      csr_addr,
    output logic [31:0]      csr_wdata,
    output logic             csr_wen,
    output logic             csr_ren,
    output logic             trap_stall,
    output logic             redirect_valid,
    output logic [31:0]      redirect_pc,
    output logic [CNT_W-1:0] trap_cnt
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_E_EPC,
        S_E_CAUSE,
        S_E_VEC,
        S_M_EPC
    } state_t;

    localparam logic [11:0] CSR_MTVEC  = 12'h305;
    localparam logic [11:0] CSR_MEPC   = 12'h341;
    localparam logic [11:0] CSR_MCAUSE = 12'h342;

    state_t      state;
    logic [31:0] pc_q;
    logic        accept;

    // A trap is taken only from IDLE; reset in the same cycle wins.
    assign accept = (state == S_IDLE) && inst_valid && (jump_ecall || jump_mret) && !rst;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            pc_q     <= 32'h0;
            trap_cnt <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        pc_q <= pc;
                        if (jump_ecall) begin
                            state <= S_E_EPC;
                            if (trap_cnt != {CNT_W{1'b1}}) begin
                                trap_cnt <= trap_cnt + CNT_W'(1);
                            end
                        end else begin
                            state <= S_M_EPC;
                        end
                    end
                end
                S_E_EPC:   state <= S_E_CAUSE;
                S_E_CAUSE: state <= S_E_VEC;
                S_E_VEC:   state <= S_IDLE;
                S_M_EPC:   state <= S_IDLE;
                default:   state <= S_IDLE;
            endcase
        end
    end

    // Reset forces every output idle so a sequence cut short issues no further access.
    always_comb begin
        csr_addr       = 12'h0;
        csr_wdata      = 32'h0;
        csr_wen        = 1'b0;
        csr_ren        = 1'b0;
        trap_stall     = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        if (!rst) begin
            case (state)
                S_IDLE: begin
                    csr_addr  = inst_csr_addr;
                    csr_wdata = inst_csr_wdata;
                    if (accept) begin
                        trap_stall = 1'b1;
                    end else begin
                        csr_wen = inst_csr_wen;
                        csr_ren = inst_csr_ren;
                    end
                end
                S_E_EPC: begin
                    csr_addr   = CSR_MEPC;
                    csr_wdata  = pc_q;
                    csr_wen    = 1'b1;
                    trap_stall = 1'b1;
                end
                S_E_CAUSE: begin
                    csr_addr   = CSR_MCAUSE;
                    csr_wdata  = MCAUSE_ECALL;
                    csr_wen    = 1'b1;
                    trap_stall = 1'b1;
                end
                S_E_VEC: begin
                    csr_addr       = CSR_MTVEC;
                    csr_ren        = 1'b1;
                    trap_stall     = 1'b1;
                    redirect_valid = 1'b1;
                    redirect_pc    = {csr_rdata[31:2], 2'b00};
                end
                S_M_EPC: begin
                    csr_addr       = CSR_MEPC;
                    csr_ren        = 1'b1;
                    trap_stall     = 1'b1;
                    redirect_valid = 1'b1;
                    redirect_pc    = csr_rdata;
                end
                default: begin
                    csr_addr = 12'h0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ysyx_23060240_trap_seq.sv
// Directed bench for the trap sequencer with a small CSR file model and
// queues of expected CSR writes and redirects.
module tb_ysyx_23060240_trap_seq;

    localparam logic [31:0] MTVEC_TGT = 32'h8000_0100;

    logic        clk = 1'b0;
    logic        rst;
    logic        inst_valid;
    logic [31:0] pc;
    logic        jump_ecall;
    logic        jump_mret;
    logic [11:0] inst_csr_addr;
    logic [31:0] inst_csr_wdata;
    logic        inst_csr_wen;
    logic        inst_csr_ren;
    logic [31:0] csr_rdata;

    logic [11:0] csr_addr;
    logic [31:0] csr_wdata;
    logic        csr_wen;
    logic        csr_ren;
    logic        trap_stall;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic [15:0] trap_cnt;

    logic [11:0] u1_csr_addr;
    logic [31:0] u1_csr_wdata;
    logic        u1_csr_wen;
    logic        u1_csr_ren;
    logic        u1_trap_stall;
    logic        u1_redirect_valid;
    logic [31:0] u1_redirect_pc;
    logic [1:0]  u1_trap_cnt;

    logic [43:0] wr_q[$];
    logic [31:0] rd_q[$];
    int          tests = 0;
    int          fails = 0;

    logic [31:0] m_mepc   = 32'h0;
    logic [31:0] m_mcause = 32'h0;
    logic [31:0] m_mtvec  = 32'h0;

    ysyx_23060240_trap_seq u0 (
        .clk(clk), .rst(rst), .inst_valid(inst_valid), .pc(pc),
        .jump_ecall(jump_ecall), .jump_mret(jump_mret),
        .inst_csr_addr(inst_csr_addr), .inst_csr_wdata(inst_csr_wdata),
        .inst_csr_wen(inst_csr_wen), .inst_csr_ren(inst_csr_ren),
        .csr_rdata(csr_rdata), .csr_addr(csr_addr), .csr_wdata(csr_wdata),
        .csr_wen(csr_wen), .csr_ren(csr_ren), .trap_stall(trap_stall),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .trap_cnt(trap_cnt)
    );

    ysyx_23060240_trap_seq #(.CNT_W(2)) u1 (
        .clk(clk), .rst(rst), .inst_valid(inst_valid), .pc(pc),
        .jump_ecall(jump_ecall), .jump_mret(jump_mret),
        .inst_csr_addr(inst_csr_addr), .inst_csr_wdata(inst_csr_wdata),
        .inst_csr_wen(inst_csr_wen), .inst_csr_ren(inst_csr_ren),
        .csr_rdata(csr_rdata), .csr_addr(u1_csr_addr), .csr_wdata(u1_csr_wdata),
        .csr_wen(u1_csr_wen), .csr_ren(u1_csr_ren), .trap_stall(u1_trap_stall),
        .redirect_valid(u1_redirect_valid), .redirect_pc(u1_redirect_pc),
        .trap_cnt(u1_trap_cnt)
    );

    always #5 clk = ~clk;

    // CSR file model: combinational read, write on negedge.
    always_comb begin
        case (csr_addr)
            12'h341: csr_rdata = m_mepc;
            12'h342: csr_rdata = m_mcause;
            12'h305: csr_rdata = m_mtvec;
            default: csr_rdata = 32'h0;
        endcase
    end

    always @(negedge clk) begin
        if (csr_wen) begin
            case (csr_addr)
                12'h341: m_mepc   <= csr_wdata;
                12'h342: m_mcause <= csr_wdata;
                12'h305: m_mtvec  <= csr_wdata;
                default: ;
            endcase
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Scoreboard: every CSR write and redirect must match the head of its queue.
    always @(negedge clk) begin
        if (csr_wen) begin
            chk("csr_write_expected", 64'(wr_q.size() > 0), 64'd1);
            if (wr_q.size() > 0) chk("csr_write", 64'({csr_addr, csr_wdata}), 64'(wr_q.pop_front()));
        end
        if (redirect_valid) begin
            chk("redirect_expected", 64'(rd_q.size() > 0), 64'd1);
            if (rd_q.size() > 0) chk("redirect_pc_sb", 64'(redirect_pc), 64'(rd_q.pop_front()));
        end
    end

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        inst_valid     = 1'b0;
        pc             = 32'h0;
        jump_ecall     = 1'b0;
        jump_mret      = 1'b0;
        inst_csr_addr  = 12'h0;
        inst_csr_wdata = 32'h0;
        inst_csr_wen   = 1'b0;
        inst_csr_ren   = 1'b0;
    endtask

    task automatic run_ecall(input logic [31:0] epc, input logic both, input logic inject,
                             input logic [15:0] cnt0, input logic [1:0] cnt1);
        next();
        wr_q.push_back({12'h341, epc});
        wr_q.push_back({12'h342, 32'hb});
        rd_q.push_back(MTVEC_TGT);
        inst_valid = 1'b1;
        pc         = epc;
        jump_ecall = 1'b1;
        jump_mret  = both;
        @(negedge clk);
        chk("accept_stall", 64'(trap_stall), 64'd1);
        chk("accept_wen", 64'(csr_wen), 64'd0);
        chk("accept_ren", 64'(csr_ren), 64'd0);
        chk("accept_redirect", 64'(redirect_valid), 64'd0);
        next();
        if (inject) begin
            inst_csr_addr  = 12'h305;
            inst_csr_wdata = 32'h1234;
            inst_csr_wen   = 1'b1;
        end
        @(negedge clk);
        chk("epc_addr", 64'(csr_addr), 64'h341);
        chk("epc_wdata", 64'(csr_wdata), 64'(epc));
        chk("epc_wen", 64'(csr_wen), 64'd1);
        chk("epc_ren", 64'(csr_ren), 64'd0);
        chk("epc_redirect", 64'(redirect_valid), 64'd0);
        chk("epc_stall", 64'(trap_stall), 64'd1);
        chk("trap_cnt", 64'(trap_cnt), 64'(cnt0));
        chk("trap_cnt_w2", 64'(u1_trap_cnt), 64'(cnt1));
        next();
        inst_csr_addr  = 12'h0;
        inst_csr_wdata = 32'h0;
        inst_csr_wen   = 1'b0;
        @(negedge clk);
        chk("cause_addr", 64'(csr_addr), 64'h342);
        chk("cause_wdata", 64'(csr_wdata), 64'hb);
        chk("cause_wen", 64'(csr_wen), 64'd1);
        chk("cause_redirect", 64'(redirect_valid), 64'd0);
        next();
        @(negedge clk);
        chk("vec_addr", 64'(csr_addr), 64'h305);
        chk("vec_ren", 64'(csr_ren), 64'd1);
        chk("vec_wen", 64'(csr_wen), 64'd0);
        chk("vec_redirect", 64'(redirect_valid), 64'd1);
        chk("vec_redirect_pc", 64'(redirect_pc), 64'(MTVEC_TGT));
        chk("vec_stall", 64'(trap_stall), 64'd1);
        next();
        idle_inputs();
        @(negedge clk);
        chk("ecall_done_stall", 64'(trap_stall), 64'd0);
        chk("ecall_done_redirect", 64'(redirect_valid), 64'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not reach the end");
        $fatal(1, "watchdog expired");
    end

    initial begin
        idle_inputs();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_wen", 64'(csr_wen), 64'd0);
        chk("rst_ren", 64'(csr_ren), 64'd0);
        chk("rst_addr", 64'(csr_addr), 64'd0);
        chk("rst_stall", 64'(trap_stall), 64'd0);
        chk("rst_redirect", 64'(redirect_valid), 64'd0);
        chk("rst_cnt", 64'(trap_cnt), 64'd0);
        next();
        rst = 1'b0;
        @(negedge clk);
        chk("idle_stall", 64'(trap_stall), 64'd0);

        // IDLE CSRRW forwarding, then program mtvec.
        next();
        inst_csr_addr  = 12'h305;
        inst_csr_wdata = 32'h1234;
        inst_csr_wen   = 1'b1;
        wr_q.push_back({12'h305, 32'h1234});
        @(negedge clk);
        chk("fwd_addr", 64'(csr_addr), 64'h305);
        chk("fwd_wdata", 64'(csr_wdata), 64'h1234);
        chk("fwd_wen", 64'(csr_wen), 64'd1);
        chk("fwd_stall", 64'(trap_stall), 64'd0);
        next();
        inst_csr_wdata = 32'h8000_0101;
        wr_q.push_back({12'h305, 32'h8000_0101});
        @(negedge clk);
        chk("fwd2_wen", 64'(csr_wen), 64'd1);
        next();
        idle_inputs();

        // Plain ECALL, then ECALL with a CSR request arriving during E_EPC.
        run_ecall(32'h8000_0010, 1'b0, 1'b0, 16'd1, 2'd1);
        run_ecall(32'h8000_0020, 1'b0, 1'b1, 16'd2, 2'd2);

        // MRET returning to mepc.
        next();
        inst_csr_addr  = 12'h341;
        inst_csr_wdata = 32'h8000_0014;
        inst_csr_wen   = 1'b1;
        wr_q.push_back({12'h341, 32'h8000_0014});
        @(negedge clk);
        next();
        idle_inputs();
        inst_valid = 1'b1;
        jump_mret  = 1'b1;
        pc         = 32'h8000_0060;
        rd_q.push_back(32'h8000_0014);
        @(negedge clk);
        chk("mret_accept_stall", 64'(trap_stall), 64'd1);
        chk("mret_accept_ren", 64'(csr_ren), 64'd0);
        chk("mret_accept_redirect", 64'(redirect_valid), 64'd0);
        next();
        @(negedge clk);
        chk("mret_addr", 64'(csr_addr), 64'h341);
        chk("mret_ren", 64'(csr_ren), 64'd1);
        chk("mret_wen", 64'(csr_wen), 64'd0);
        chk("mret_redirect", 64'(redirect_valid), 64'd1);
        chk("mret_redirect_pc", 64'(redirect_pc), 64'h8000_0014);
        chk("mret_stall", 64'(trap_stall), 64'd1);
        chk("mret_cnt", 64'(trap_cnt), 64'd2);
        next();
        idle_inputs();
        @(negedge clk);
        chk("mret_done_stall", 64'(trap_stall), 64'd0);
        chk("mret_done_redirect", 64'(redirect_valid), 64'd0);

        // ECALL and MRET together: ECALL wins.
        run_ecall(32'h8000_0030, 1'b1, 1'b0, 16'd3, 2'd3);

        // Reset while in E_CAUSE.
        next();
        wr_q.push_back({12'h341, 32'h8000_0040});
        inst_valid = 1'b1;
        jump_ecall = 1'b1;
        pc         = 32'h8000_0040;
        @(negedge clk);
        chk("r_accept_stall", 64'(trap_stall), 64'd1);
        next();
        @(negedge clk);
        chk("r_epc_wen", 64'(csr_wen), 64'd1);
        chk("r_cnt", 64'(trap_cnt), 64'd4);
        next();
        rst = 1'b1;
        @(negedge clk);
        chk("r_cause_wen", 64'(csr_wen), 64'd0);
        chk("r_cause_redirect", 64'(redirect_valid), 64'd0);
        next();
        rst = 1'b0;
        idle_inputs();
        @(negedge clk);
        chk("r_after_stall", 64'(trap_stall), 64'd0);
        chk("r_after_cnt", 64'(trap_cnt), 64'd0);
        chk("r_after_redirect", 64'(redirect_valid), 64'd0);
        next();
        @(negedge clk);
        chk("r_after2_redirect", 64'(redirect_valid), 64'd0);
        chk("r_after2_wen", 64'(csr_wen), 64'd0);

        // Saturation of a 2-bit counter.
        for (int i = 1; i <= 5; i++) begin
            run_ecall(32'h8000_0200 + 32'(i * 4), 1'b0, 1'b0, 16'(i), (i > 3) ? 2'd3 : 2'(i));
        end

        chk("wr_q_empty", 64'(wr_q.size()), 64'd0);
        chk("rd_q_empty", 64'(rd_q.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
